// File: rtl/chip_det_pkg.sv
// Shared types and constants for the chip detector and its magnitude stage.
// The helper gives the saturated magnitude of a signed 16-bit sample.
package chip_det_pkg;

  localparam int TS_W_DEF  = 32;
  localparam int LEN_W_DEF = 8;

  localparam logic [15:0] MAG_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } det_state_e;

  // -32768 has no positive counterpart in 16 bits, so it clips to MAG_MAX.
  function automatic logic [15:0] sat_abs(input logic [15:0] s);
    logic [15:0] r;
    if (s == 16'h8000)
      r = MAG_MAX;
    else if (s[15])
      r = ~s + 16'd1;
    else
      r = s;
    return r;
  endfunction

endpackage

// File: rtl/chip_mag.sv
// Registered saturated-magnitude stage with its valid pipeline bit.
// Reusable front end for any threshold detector fed by a signed sample stream.
module chip_mag
  import chip_det_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] d1_data,
  input  logic        d1_vld,
  input  logic        cfg_en,
  output logic [15:0] mag_q,
  output logic        vld_q
);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      mag_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= d1_vld & cfg_en;
      if (d1_vld)
        mag_q <= sat_abs(d1_data);
    end
  end

endmodule

// File: rtl/chip_det.sv
// Chip detector: qualifies runs of above-threshold sample magnitudes and emits
// one peak/length/timestamp record per chip, followed by an optional holdoff.
module chip_det
  import chip_det_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [15:0]      d1_data,
  input  logic             d1_vld,
  input  logic             cfg_en,
  input  logic [15:0]      cfg_chip_th,
  input  logic [LEN_W-1:0] cfg_chip_min,
  input  logic [LEN_W-1:0] cfg_chip_hold,
  output logic             chip_vld,
  output logic [15:0]      chip_peak,
  output logic [LEN_W-1:0] chip_len,
  output logic [TS_W-1:0]  chip_ts,
  output logic [15:0]      chip_cnt,
  output logic             det_busy
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic [15:0]      mag_q;
  logic             vld_q;

  det_state_e       state_q, state_d;
  logic [TS_W-1:0]  ts_q;
  logic [15:0]      run_peak_q, run_peak_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic [TS_W-1:0]  run_ts_q, run_ts_d;
  logic [LEN_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             emit;

  logic             above;
  logic [LEN_W-1:0] min_eff;
  logic [LEN_W-1:0] hold_nxt;

  chip_mag u_chip_mag (
    .clk_sys (clk_sys),
    .rst     (rst),
    .d1_data (d1_data),
    .d1_vld  (d1_vld),
    .cfg_en  (cfg_en),
    .mag_q   (mag_q),
    .vld_q   (vld_q)
  );

  assign above    = (mag_q >= cfg_chip_th);
  assign min_eff  = (cfg_chip_min == '0) ? LEN_W'(1) : cfg_chip_min;
  assign hold_nxt = hold_cnt_q + 1'b1;
  assign det_busy = (state_q != IDLE);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    run_peak_d = run_peak_q;
    run_len_d  = run_len_q;
    run_ts_d   = run_ts_q;
    hold_cnt_d = hold_cnt_q;
    emit       = 1'b0;

    if (!cfg_en) begin
      // Disabling aborts any chip in progress without a record.
      state_d = IDLE;
    end else if (vld_q) begin
      unique case (state_q)
        IDLE: begin
          if (above) begin
            state_d    = ACTIVE;
            run_peak_d = mag_q;
            run_len_d  = LEN_W'(1);
            run_ts_d   = ts_q;
          end
        end

        ACTIVE: begin
          if (above) begin
            if (run_len_q != LEN_MAX) begin
              run_len_d  = run_len_q + 1'b1;
              run_peak_d = (mag_q > run_peak_q) ? mag_q : run_peak_q;
            end else begin
              // Length cap: the capping sample closes the chip but is not counted.
              emit       = 1'b1;
              state_d    = HOLD;
              hold_cnt_d = '0;
            end
          end else if (run_len_q >= min_eff) begin
            emit       = 1'b1;
            state_d    = (cfg_chip_hold == '0) ? IDLE : HOLD;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end

        HOLD: begin
          hold_cnt_d = hold_nxt;
          if (hold_nxt >= cfg_chip_hold)
            state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      run_peak_q <= '0;
      run_len_q  <= '0;
      run_ts_q   <= '0;
      hold_cnt_q <= '0;
      chip_vld   <= 1'b0;
      chip_peak  <= '0;
      chip_len   <= '0;
      chip_ts    <= '0;
      chip_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      run_peak_q <= run_peak_d;
      run_len_q  <= run_len_d;
      run_ts_q   <= run_ts_d;
      hold_cnt_q <= hold_cnt_d;
      if (vld_q && cfg_en)
        ts_q <= ts_q + 1'b1;

      chip_vld <= emit;
      if (emit) begin
        chip_peak <= run_peak_q;
        chip_len  <= run_len_q;
        chip_ts   <= run_ts_q;
        chip_cnt  <= chip_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_chip_det.sv
// Self-checking bench for chip_det: directed vector tables, corner sequences
// and randomized stimulus against a sample-level behavioural model.
module tb_chip_det;

  localparam int LEN_MAX_I = 255;

  logic        clk_sys;
  logic        rst;
  logic [15:0] d1_data;
  logic        d1_vld;
  logic        cfg_en;
  logic [15:0] cfg_chip_th;
  logic [7:0]  cfg_chip_min;
  logic [7:0]  cfg_chip_hold;
  logic        chip_vld;
  logic [15:0] chip_peak;
  logic [7:0]  chip_len;
  logic [31:0] chip_ts;
  logic [15:0] chip_cnt;
  logic        det_busy;

  chip_det #(.TS_W(32), .LEN_W(8)) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .d1_data       (d1_data),
    .d1_vld        (d1_vld),
    .cfg_en        (cfg_en),
    .cfg_chip_th   (cfg_chip_th),
    .cfg_chip_min  (cfg_chip_min),
    .cfg_chip_hold (cfg_chip_hold),
    .chip_vld      (chip_vld),
    .chip_peak     (chip_peak),
    .chip_len      (chip_len),
    .chip_ts       (chip_ts),
    .chip_cnt      (chip_cnt),
    .det_busy      (det_busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus settings applied at the next step.
  int s_rst, s_en, s_th, s_min, s_hold;

  // Behavioural model: one sample in flight, chip run, holdoff, timestamp.
  int          m_pend, m_pend_mag;
  int          m_run, m_len, m_peak;
  int unsigned m_rts;
  int          m_hold, m_hold_seen;
  int unsigned m_ts;
  // Expected DUT outputs at the next check.
  int          e_vld, e_busy, e_cnt, e_peak, e_len;
  int unsigned e_ts;

  function automatic int sat_mag(input logic [15:0] d);
    int v;
    v = $signed(d);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_pend_mag = 0;
    m_run = 0; m_len = 0; m_peak = 0; m_rts = 0;
    m_hold = 0; m_hold_seen = 0; m_ts = 0;
    e_vld = 0; e_busy = 0; e_cnt = 0; e_peak = 0; e_len = 0; e_ts = 0;
  endtask

  task automatic model_emit();
    e_vld  = 1;
    e_peak = m_peak;
    e_len  = m_len;
    e_ts   = m_rts;
    e_cnt  = (e_cnt + 1) % 65536;
  endtask

  // Evaluate one accepted sample against the detection rules.
  task automatic model_eval(input int mag);
    int unsigned ts;
    int minv;
    int above;
    ts    = m_ts;
    m_ts  = m_ts + 1;
    above = (mag >= s_th);
    minv  = (s_min == 0) ? 1 : s_min;
    if (m_hold != 0) begin
      m_hold_seen++;
      if (m_hold_seen >= s_hold) m_hold = 0;
    end else if (m_run == 0) begin
      if (above != 0) begin
        m_run = 1; m_len = 1; m_peak = mag; m_rts = ts;
      end
    end else if (above != 0) begin
      if (m_len < LEN_MAX_I) begin
        m_len++;
        if (mag > m_peak) m_peak = mag;
      end else begin
        model_emit();
        m_run = 0; m_hold = 1; m_hold_seen = 0;
      end
    end else begin
      if (m_len >= minv) begin
        model_emit();
        m_hold = (s_hold != 0) ? 1 : 0;
        m_hold_seen = 0;
      end
      m_run = 0;
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance model.
  // A sample driven now is evaluated by the detector one clock later.
  task automatic step(input bit v, input logic [15:0] d);
    @(negedge clk_sys);
    check("chip_vld",  32'(chip_vld),  32'(e_vld));
    check("det_busy",  32'(det_busy),  32'(e_busy));
    check("chip_cnt",  32'(chip_cnt),  32'(e_cnt));
    check("chip_peak", 32'(chip_peak), 32'(e_peak));
    check("chip_len",  32'(chip_len),  32'(e_len));
    check("chip_ts",   chip_ts,        e_ts);
    rst           = (s_rst != 0);
    cfg_en        = (s_en != 0);
    cfg_chip_th   = 16'(s_th);
    cfg_chip_min  = 8'(s_min);
    cfg_chip_hold = 8'(s_hold);
    d1_vld        = v;
    d1_data       = d;
    e_vld = 0;
    if (s_rst != 0) begin
      model_reset();
    end else begin
      if (s_en == 0) begin
        m_run = 0; m_hold = 0;
      end else if (m_pend != 0) begin
        model_eval(m_pend_mag);
      end
      m_pend     = (v && s_en != 0) ? 1 : 0;
      m_pend_mag = sat_mag(d);
    end
    e_busy = (m_run != 0 || m_hold != 0) ? 1 : 0;
  endtask

  task automatic do_reset();
    s_rst = 1;
    step(1'b0, 16'h0);
    s_rst = 0;
  endtask

  typedef struct {
    bit          vld;
    logic [15:0] data;
    int          e_vld;
    int          e_busy;
    int          e_cnt;
    int          e_peak;
    int          e_len;
    int          e_ts;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit v, input int d, input int ev, input int eb,
                              input int ec, input int ep, input int el, input int et);
    vec_t r;
    r.vld = v; r.data = 16'(d);
    r.e_vld = ev; r.e_busy = eb; r.e_cnt = ec;
    r.e_peak = ep; r.e_len = el; r.e_ts = et;
    return r;
  endfunction

  // Expected values in each row are the outputs seen when that row is applied.
  task automatic run_vectors(input string tag);
    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].data);
      check({tag, "_vld"},  32'(chip_vld),  32'(tbl[i].e_vld));
      check({tag, "_busy"}, 32'(det_busy),  32'(tbl[i].e_busy));
      check({tag, "_cnt"},  32'(chip_cnt),  32'(tbl[i].e_cnt));
      check({tag, "_peak"}, 32'(chip_peak), 32'(tbl[i].e_peak));
      check({tag, "_len"},  32'(chip_len),  32'(tbl[i].e_len));
      check({tag, "_ts"},   chip_ts,        32'(tbl[i].e_ts));
    end
    tbl.delete();
  endtask

  int cap_peak[$], cap_len[$], cap_ts[$];

  initial begin
    rst = 1'b1; d1_vld = 1'b0; d1_data = '0; cfg_en = 1'b0;
    cfg_chip_th = '0; cfg_chip_min = '0; cfg_chip_hold = '0;
    model_reset();
    s_rst = 1; s_en = 1; s_th = 100; s_min = 3; s_hold = 0;
    repeat (2) @(posedge clk_sys);

    // Basic chip: peak from the negative sample, ts of the first above sample.
    s_th = 100; s_min = 3; s_hold = 0;
    do_reset();
    tbl.push_back(mk(1, 0,    0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(1, 150,  0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(1, -200, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(1, 120,  0, 1, 0, 0,   0, 0));
    tbl.push_back(mk(1, 50,   0, 1, 0, 0,   0, 0));
    tbl.push_back(mk(0, 0,    0, 1, 0, 0,   0, 0));
    tbl.push_back(mk(0, 0,    1, 0, 1, 200, 3, 1));
    tbl.push_back(mk(0, 0,    0, 0, 1, 200, 3, 1));
    run_vectors("basic");

    // Too short: discarded, no record.
    s_th = 100; s_min = 3; s_hold = 0;
    do_reset();
    tbl.push_back(mk(1, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 150, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 120, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 10,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 0, 0, 0));
    run_vectors("short");

    // Holdoff of two samples swallows 500 and 600.
    s_th = 100; s_min = 1; s_hold = 2;
    do_reset();
    tbl.push_back(mk(1, 150, 0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(1, 10,  0, 0, 0, 0,   0, 0));
    tbl.push_back(mk(1, 500, 0, 1, 0, 0,   0, 0));
    tbl.push_back(mk(1, 600, 1, 1, 1, 150, 1, 0));
    tbl.push_back(mk(1, 10,  0, 1, 1, 150, 1, 0));
    tbl.push_back(mk(1, 200, 0, 0, 1, 150, 1, 0));
    tbl.push_back(mk(1, 10,  0, 0, 1, 150, 1, 0));
    tbl.push_back(mk(0, 0,   0, 1, 1, 150, 1, 0));
    tbl.push_back(mk(0, 0,   1, 1, 2, 200, 1, 5));
    tbl.push_back(mk(0, 0,   0, 1, 2, 200, 1, 5));
    run_vectors("hold");

    // Disable mid-chip: aborted, busy drops, count unchanged.
    s_en = 0; step(1'b0, 16'h0);
    s_en = 1; s_th = 100; s_min = 1; s_hold = 0;
    step(1'b1, 16'd200);
    step(1'b1, 16'd200);
    step(1'b0, 16'h0);
    s_en = 0; step(1'b0, 16'h0);
    check("en_drop_busy_before", 32'(det_busy), 32'd1);
    s_en = 1; step(1'b0, 16'h0);
    check("en_drop_busy_after", 32'(det_busy), 32'd0);
    check("en_drop_no_vld",     32'(chip_vld), 32'd0);
    check("en_drop_cnt",        32'(chip_cnt), 32'd2);
    repeat (3) step(1'b0, 16'h0);

    // Reset mid-chip: no record, counter and timestamp cleared.
    step(1'b1, 16'd300);
    step(1'b1, 16'd300);
    step(1'b0, 16'h0);
    check("rst_busy_before", 32'(det_busy), 32'd1);
    do_reset();
    step(1'b0, 16'h0);
    check("rst_busy", 32'(det_busy), 32'd0);
    check("rst_vld",  32'(chip_vld), 32'd0);
    check("rst_cnt",  32'(chip_cnt), 32'd0);
    check("rst_ts",   chip_ts,       32'd0);

    // Saturation of 16'h8000 and equality with the threshold.
    s_th = 32767; s_min = 1; s_hold = 0;
    do_reset();
    tbl.push_back(mk(1, 32'h8000, 0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(1, 0,        0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(1, 32'h8001, 0, 1, 0, 0,     0, 0));
    tbl.push_back(mk(1, 0,        1, 0, 1, 32767, 1, 0));
    tbl.push_back(mk(1, 32'h8002, 0, 1, 1, 32767, 1, 0));
    tbl.push_back(mk(0, 0,        1, 0, 2, 32767, 1, 2));
    tbl.push_back(mk(0, 0,        0, 0, 2, 32767, 1, 2));
    run_vectors("sat");

    // Length cap: 300 above samples, cap at 255, holdoff 3, restart at ts 259.
    s_th = 0; s_min = 1; s_hold = 3;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 16'd7);
      if (chip_vld) begin
        cap_peak.push_back(chip_peak); cap_len.push_back(chip_len); cap_ts.push_back(chip_ts);
      end
    end
    s_th = 1;
    step(1'b1, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0);
      if (chip_vld) begin
        cap_peak.push_back(chip_peak); cap_len.push_back(chip_len); cap_ts.push_back(chip_ts);
      end
    end
    check("cap_records", 32'(cap_len.size()), 32'd2);
    if (cap_len.size() >= 2) begin
      check("cap0_len",  32'(cap_len[0]),  32'd255);
      check("cap0_ts",   32'(cap_ts[0]),   32'd0);
      check("cap0_peak", 32'(cap_peak[0]), 32'd7);
      check("cap1_len",  32'(cap_len[1]),  32'd41);
      check("cap1_ts",   32'(cap_ts[1]),   32'd259);
    end

    // Randomized traffic with occasional config changes, disables and resets.
    s_th = 500; s_min = 2; s_hold = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int sel, m;
      logic [15:0] d;
      if ($urandom_range(0, 99) == 0) begin
        s_th   = $urandom_range(0, 2000);
        s_min  = $urandom_range(0, 5);
        s_hold = $urandom_range(0, 4);
      end
      s_en  = ($urandom_range(0, 199) != 0) ? 1 : 0;
      s_rst = ($urandom_range(0, 599) == 0) ? 1 : 0;
      sel = $urandom_range(0, 9);
      if (sel == 0)
        m = 32768;
      else if (sel < 4)
        m = s_th + $urandom_range(0, 2) - 1;
      else
        m = $urandom_range(0, 2500);
      if (m < 0) m = 0;
      d = ($urandom_range(0, 1) != 0) ? 16'(-m) : 16'(m);
      step($urandom_range(0, 9) < 8, d);
    end
    s_rst = 0; s_en = 1;
    repeat (4) step(1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
